// File: rtl/sbd_deserializer_left2.sv
// Rebuilds a parallel word from an MSB-first 2-bit pair stream and presents it
// through a registered holding stage with a valid/ready handshake.
module sbd_deserializer_left2 #(
  parameter int bitlength = 24
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic [1:0]           SIN,
  input  logic                 SVALID,
  output logic                 SREADY,
  output logic [bitlength-1:0] POUT,
  output logic                 PVALID,
  input  logic                 PREADY,
  output logic                 BUSY,
  output logic                 state_o
);

  localparam int N  = bitlength / 2;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(N);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the holding register (POUT) is
  // frozen while PVALID=1 and PREADY=0.

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [bitlength-1:0] sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [bitlength-1:0] pout_q, pout_d;
  logic                 pvalid_q, pvalid_d;

  logic                 sready;
  logic                 accept;
  logic                 drain;
  logic [bitlength-1:0] word;

  assign sready = (state_q == S_FILL) && !CLR;
  assign accept = SVALID && sready;
  assign drain  = pvalid_q && PREADY;
  assign word   = {sr_q[bitlength-3:0], SIN};

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    pout_d   = pout_q;
    pvalid_d = pvalid_q;
    case (state_q)
      S_FILL: begin
        if (drain) pvalid_d = 1'b0;
        if (CLR) begin
          sr_d  = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == LAST_CNT) begin
            if (!pvalid_q || drain) begin
              // Word moves straight into the holding register, no bubble.
              pout_d   = word;
              pvalid_d = 1'b1;
              sr_d     = '0;
              cnt_d    = '0;
            end else begin
              sr_d    = word;
              cnt_d   = FULL_CNT;
              state_d = S_FULL;
            end
          end else begin
            sr_d  = word;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FULL: begin
        if (CLR) begin
          // Held word is discarded; an output handshake still completes.
          sr_d    = '0;
          cnt_d   = '0;
          state_d = S_FILL;
          if (drain) pvalid_d = 1'b0;
        end else if (drain) begin
          pout_d   = sr_q;
          pvalid_d = 1'b1;
          sr_d     = '0;
          cnt_d    = '0;
          state_d  = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_FILL;
      sr_q     <= '0;
      cnt_q    <= '0;
      pout_q   <= '0;
      pvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      pout_q   <= pout_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign SREADY  = sready;
  assign POUT    = pout_q;
  assign PVALID  = pvalid_q;
  assign BUSY    = (cnt_q != '0);
  assign state_o = (state_q == S_FULL);

endmodule
